// File: rtl/cla_seq_adder.sv
// cla_seq_adder: nibble-serial WIDTH-bit adder on one cla4bit slice; ports clk, rst, start, in0, in1, cin -> busy, done, sum, cout
module cla4bit (
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [3:1] c;
  assign g = in0 & in1;
  assign p = in0 ^ in1;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum = p ^ {c, cin};
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [NIB-1:0][3:0] op_a, op_b, res;
  logic [IW-1:0] idx;
  logic carry, s_cout;
  logic [3:0] s_sum;
  cla4bit u_slice (
    .in0 (op_a[idx]),
    .in1 (op_b[idx]),
    .cin (carry),
    .sum (s_sum),
    .cout(s_cout)
  );
  assign busy = state == RUN;
  assign done = state == DONE;
  assign sum = res;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      carry <= 1'b0;
      cout <= 1'b0;
      idx <= '0;
    end else if (state != RUN) begin
      if (start) begin
        op_a <= in0;
        op_b <= in1;
        carry <= cin;
        res <= '0;
        cout <= 1'b0;
        idx <= '0;
        state <= RUN;
      end else begin
        state <= IDLE;
      end
    end else begin
      res[idx] <= s_sum;
      carry <= s_cout;
      if (idx == IW'(NIB - 1)) begin
        cout <= s_cout;
        state <= DONE;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: table, random and corner-sequence checks of cla_seq_adder at WIDTH=16
module tb_cla_seq_adder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [15:0] in0 = '0, in1 = '0;
  logic busy, done, cout;
  logic [15:0] sum;
  int total = 0, bad = 0;
  typedef struct {
    logic [15:0] a, b;
    logic ci;
    logic [15:0] s;
    logic co;
  } vec_t;
  vec_t tv[6];
  cla_seq_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in0(in0), .in1(in1), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
    @(negedge clk);
    in0 = a; in1 = b; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      if (busy) n++;
      @(negedge clk);
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [15:0] es, input logic eco);
    int n;
    start_op(a, b, ci);
    wait_done(n);
    chk({name, "_lat"}, n, 4);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(eco));
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask
  initial begin
    int n, pulses;
    logic [16:0] r;
    logic [15:0] a, b;
    logic ci;
    tv[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tv[1] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tv[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tv[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tv[4] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
    tv[5] = '{16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0};
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) do_op($sformatf("tv%0d", i), tv[i].a, tv[i].b, tv[i].ci, tv[i].s, tv[i].co);
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      r = 17'(a) + 17'(b) + 17'(ci);
      do_op($sformatf("rnd%0d", i), a, b, ci, r[15:0], r[16]);
    end
    start_op(16'h1234, 16'h1111, 1'b0);
    in0 = 16'hFFFF; in1 = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        pulses++;
        chk("ign_sum", 32'(sum), 32'h2345);
        chk("ign_cout", 32'(cout), 32'd0);
      end
      chk("ign_busy_done_excl", 32'(busy & done), 32'd0);
      @(negedge clk);
    end
    chk("ign_pulses", pulses, 1);
    start_op(16'h00FF, 16'h0001, 1'b0);
    wait_done(n);
    chk("b2b_sum1", 32'(sum), 32'h0100);
    chk("b2b_cout1", 32'(cout), 32'd0);
    in0 = 16'h000F; in1 = 16'h000F; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    wait_done(n);
    chk("b2b_lat", n, 4);
    chk("b2b_sum2", 32'(sum), 32'h001F);
    chk("b2b_cout2", 32'(cout), 32'd0);
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
